// File: rtl/wfq_pkg.sv
// Shared constants and FSM encoding for the WFQ virtual-time / finish-tag stage.
package wfq_pkg;

    localparam int PKG_N       = 16;
    localparam int PKG_F_SHIFT = 8;
    localparam int PKG_FLOW_W  = PKG_N - 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIV_V = 3'd1,
        ST_UPD_V = 3'd2,
        ST_RD_F  = 3'd3,
        ST_DIV_F = 3'd4,
        ST_TAG   = 3'd5
    } state_t;

endpackage

// File: rtl/seq_div.sv
// Restoring divider computing (num << F_SHIFT) / den in N iterations.
// The upper F_SHIFT bits of the shifted dividend are preloaded as the partial
// remainder; if they already reach den the quotient cannot fit in N bits and
// saturates. A zero divisor also saturates to all ones.
module seq_div #(
    parameter int N       = 16,
    parameter int F_SHIFT = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] num_i,
    input  logic [N-1:0] den_i,
    output logic         done_o,   // final iteration happens at this edge
    output logic [N-1:0] quo_o     // valid from the cycle after done_o
);

    localparam int CW = $clog2(N + 1);

    logic [N:0]    rem_q;
    logic [N-1:0]  lo_q;
    logic [N-1:0]  quo_q;
    logic [N-1:0]  den_q;
    logic [CW-1:0] cnt_q;
    logic          sat_q;

    logic [N-1:0]  hi_s;
    logic [N-1:0]  lo_s;
    logic [N:0]    rem_sh_s;
    logic [N:0]    rem_d;
    logic          qbit_s;

    assign hi_s = num_i >> (N - F_SHIFT);
    assign lo_s = num_i << F_SHIFT;

    // One restoring step: shift in the next dividend bit and try to subtract.
    always_comb begin
        rem_sh_s = {rem_q[N-1:0], lo_q[N-1]};
        rem_d    = rem_sh_s;
        qbit_s   = 1'b0;
        if (rem_sh_s >= {1'b0, den_q}) begin
            rem_d  = rem_sh_s - {1'b0, den_q};
            qbit_s = 1'b1;
        end else begin
            rem_d  = rem_sh_s;
            qbit_s = 1'b0;
        end
    end

    // Load operands on start, then iterate until the counter runs out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q <= '0;
            lo_q  <= '0;
            quo_q <= '0;
            den_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (start_i) begin
            rem_q <= {1'b0, hi_s};
            lo_q  <= lo_s;
            quo_q <= '0;
            den_q <= den_i;
            cnt_q <= CW'(N);
            sat_q <= (den_i == '0) || (hi_s >= den_i);
        end else if (cnt_q != '0) begin
            rem_q <= rem_d;
            lo_q  <= {lo_q[N-2:0], 1'b0};
            quo_q <= {quo_q[N-2:0], qbit_s};
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign done_o = (cnt_q == CW'(1));
    assign quo_o  = sat_q ? '1 : quo_q;

endmodule

// File: rtl/virtual_time_tag.sv
// WFQ virtual time tracker and finish-tag generator. Each accepted event
// advances virtual time by delta_t / sum_w_prev; arrivals additionally get a
// finish tag F = max(V, F_last) + len / w, stored back per flow.
module virtual_time_tag
    import wfq_pkg::*;
#(
    parameter int N       = PKG_N,
    parameter int F_SHIFT = PKG_F_SHIFT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         evt_valid,
    input  logic         evt_arrival,
    input  logic [N-4:0] flow_id,
    input  logic [N-1:0] pkt_len,
    input  logic [N-1:0] sum_w,
    input  logic [N-1:0] flow_w,
    input  logic [N-1:0] delta_t,
    input  logic         flow_idle,
    output logic         busy,
    output logic [N-1:0] vtime,
    output logic         tag_valid,
    output logic [N-1:0] finish_tag,
    output logic [N-4:0] tag_flow,
    output logic         err_ovf
);

    localparam int FW = N - 3;

    state_t        state_q;
    logic          busy_q;
    logic [N-1:0]  vtime_q;
    logic [N-1:0]  sum_w_prev_q;
    logic          tag_valid_q;
    logic [N-1:0]  finish_tag_q;
    logic [FW-1:0] tag_flow_q;
    logic          err_ovf_q;

    logic          arrival_q;
    logic [FW-1:0] flow_q;
    logic [N-1:0]  len_q;
    logic [N-1:0]  sumw_q;
    logic [N-1:0]  fw_q;
    logic          idle_q;
    logic [N-1:0]  s_q;

    logic [N-1:0]  f_last_mem [0:(2**FW)-1];
    logic [N-1:0]  f_rd_q;

    logic          accept_s;
    logic          div_start_s;
    logic [N-1:0]  div_num_s;
    logic [N-1:0]  div_den_s;
    logic          div_done_s;
    logic [N-1:0]  div_quo_s;
    logic [N-1:0]  inc_s;
    logic [N-1:0]  diff_s;
    logic [N-1:0]  s_d;
    logic [N-1:0]  f_s;

    assign accept_s = evt_valid && !busy_q;

    // Feed the shared divider: vtime increment from IDLE, tag quotient from RD_F.
    always_comb begin
        div_start_s = 1'b0;
        div_num_s   = '0;
        div_den_s   = '0;
        case (state_q)
            ST_IDLE: begin
                div_start_s = accept_s;
                div_num_s   = delta_t;
                div_den_s   = sum_w_prev_q;
            end
            ST_RD_F: begin
                div_start_s = 1'b1;
                div_num_s   = len_q;
                div_den_s   = fw_q;
            end
            default: begin
                div_start_s = 1'b0;
                div_num_s   = '0;
                div_den_s   = '0;
            end
        endcase
    end

    seq_div #(.N(N), .F_SHIFT(F_SHIFT)) u_div (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (div_start_s),
        .num_i   (div_num_s),
        .den_i   (div_den_s),
        .done_o  (div_done_s),
        .quo_o   (div_quo_s)
    );

    // Empty system (no previous weight) leaves virtual time frozen.
    assign inc_s  = (sum_w_prev_q == '0) ? '0 : div_quo_s;

    // Serial-number compare: the sign of V - F_last picks the later value.
    assign diff_s = vtime_q - f_rd_q;
    assign s_d    = idle_q ? vtime_q : (diff_s[N-1] ? f_rd_q : vtime_q);
    assign f_s    = s_q + div_quo_s;

    // Main sequencer: capture, divide, update V, read F_last, divide, tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            vtime_q      <= '0;
            sum_w_prev_q <= '0;
            tag_valid_q  <= 1'b0;
            finish_tag_q <= '0;
            tag_flow_q   <= '0;
            arrival_q    <= 1'b0;
            flow_q       <= '0;
            len_q        <= '0;
            sumw_q       <= '0;
            fw_q         <= '0;
            idle_q       <= 1'b0;
            s_q          <= '0;
        end else begin
            tag_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        arrival_q <= evt_arrival;
                        flow_q    <= flow_id;
                        len_q     <= pkt_len;
                        sumw_q    <= sum_w;
                        fw_q      <= flow_w;
                        idle_q    <= flow_idle;
                        busy_q    <= 1'b1;
                        state_q   <= ST_DIV_V;
                    end
                end
                ST_DIV_V: begin
                    if (div_done_s) begin
                        state_q <= ST_UPD_V;
                    end
                end
                ST_UPD_V: begin
                    vtime_q      <= vtime_q + inc_s;
                    sum_w_prev_q <= sumw_q;
                    if (arrival_q) begin
                        state_q <= ST_RD_F;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD_F: begin
                    s_q     <= s_d;
                    state_q <= ST_DIV_F;
                end
                ST_DIV_F: begin
                    if (div_done_s) begin
                        state_q <= ST_TAG;
                    end
                end
                ST_TAG: begin
                    tag_valid_q  <= 1'b1;
                    finish_tag_q <= f_s;
                    tag_flow_q   <= flow_q;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow flag for events offered while a computation is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
        end else if (evt_valid && busy_q) begin
            err_ovf_q <= 1'b1;
        end
    end

    // Single-port F_last RAM: write in TAG, otherwise read the captured flow.
    always_ff @(posedge clk) begin
        if (state_q == ST_TAG) begin
            f_last_mem[flow_q] <= f_s;
        end else begin
            f_rd_q <= f_last_mem[flow_q];
        end
    end

    assign busy       = busy_q;
    assign vtime      = vtime_q;
    assign tag_valid  = tag_valid_q;
    assign finish_tag = finish_tag_q;
    assign tag_flow   = tag_flow_q;
    assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_virtual_time_tag.sv
// Directed, table-driven bench for virtual_time_tag (N=16, F_SHIFT=8).
module tb_virtual_time_tag;

    logic        clk;
    logic        rst;
    logic        evt_valid;
    logic        evt_arrival;
    logic [12:0] flow_id;
    logic [15:0] pkt_len;
    logic [15:0] sum_w;
    logic [15:0] flow_w;
    logic [15:0] delta_t;
    logic        flow_idle;
    logic        busy;
    logic [15:0] vtime;
    logic        tag_valid;
    logic [15:0] finish_tag;
    logic [12:0] tag_flow;
    logic        err_ovf;

    int n_cmp;
    int n_err;

    virtual_time_tag #(.N(16), .F_SHIFT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .evt_valid   (evt_valid),
        .evt_arrival (evt_arrival),
        .flow_id     (flow_id),
        .pkt_len     (pkt_len),
        .sum_w       (sum_w),
        .flow_w      (flow_w),
        .delta_t     (delta_t),
        .flow_idle   (flow_idle),
        .busy        (busy),
        .vtime       (vtime),
        .tag_valid   (tag_valid),
        .finish_tag  (finish_tag),
        .tag_flow    (tag_flow),
        .err_ovf     (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        arr;
        logic [12:0] flow;
        logic [15:0] len;
        logic [15:0] fw;
        logic [15:0] sw;
        logic [15:0] dt;
        logic        idle;
        logic        dup;
        logic [15:0] exp_v;
        logic [15:0] exp_f;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input logic arr, input logic [12:0] flow,
                                input logic [15:0] len, input logic [15:0] fw,
                                input logic [15:0] sw, input logic [15:0] dt,
                                input logic idle, input logic dup,
                                input logic [15:0] exp_v, input logic [15:0] exp_f,
                                input logic exp_err);
        vec_t v;
        v.arr = arr; v.flow = flow; v.len = len; v.fw = fw; v.sw = sw;
        v.dt = dt; v.idle = idle; v.dup = dup; v.exp_v = exp_v;
        v.exp_f = exp_f; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        evt_valid   = 1'b1;
        evt_arrival = v.arr;
        flow_id     = v.flow;
        pkt_len     = v.len;
        flow_w      = v.fw;
        sum_w       = v.sw;
        delta_t     = v.dt;
        flow_idle   = v.idle;
    endtask

    // Offer one event and watch 40 cycles; cycle k is sampled at its negedge.
    task automatic run_event(input vec_t v, input string id);
        int          ntag;
        int          tcyc;
        logic [15:0] tf;
        logic [12:0] tfl;
        ntag = 0; tcyc = 0; tf = 16'h0000; tfl = 13'h0000;
        @(negedge clk);
        chk({id, ".ready"}, {31'd0, busy}, 32'd0);
        drive(v);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) evt_valid = 1'b0;
            if (v.dup && k == 5) evt_valid = 1'b1;
            if (v.dup && k == 6) evt_valid = 1'b0;
            if (tag_valid) begin
                ntag++;
                tcyc = k;
                tf   = finish_tag;
                tfl  = tag_flow;
            end
            if (k == 17) chk({id, ".busy17"}, {31'd0, busy}, 32'd1);
            if (k == 18) begin
                chk({id, ".vtime18"}, {16'd0, vtime}, {16'd0, v.exp_v});
                chk({id, ".busy18"}, {31'd0, busy}, {31'd0, v.arr});
            end
            if (k == 36 && v.arr) chk({id, ".busy36"}, {31'd0, busy}, 32'd0);
        end
        chk({id, ".ntags"}, ntag, v.arr ? 32'd1 : 32'd0);
        if (v.arr) begin
            chk({id, ".tag_cycle"}, tcyc, 32'd36);
            chk({id, ".finish_tag"}, {16'd0, tf}, {16'd0, v.exp_f});
            chk({id, ".tag_flow"}, {19'd0, tfl}, {19'd0, v.flow});
        end
        chk({id, ".err_ovf"}, {31'd0, err_ovf}, {31'd0, v.exp_err});
    endtask

    vec_t vecs [10];
    vec_t vrst;
    vec_t vpost;
    int   stray;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        evt_valid = 1'b0; evt_arrival = 1'b0; flow_id = 13'd0; pkt_len = 16'd0;
        sum_w = 16'd0; flow_w = 16'd0; delta_t = 16'd0; flow_idle = 1'b0;

        //             arr   flow    len       fw      sw      dt       idle  dup   exp_v     exp_f     err
        vecs[0] = mk(1'b1, 13'd5, 16'd64,   16'd4, 16'd4, 16'd10,   1'b1, 1'b0, 16'h0000, 16'h1000, 1'b0);
        vecs[1] = mk(1'b1, 13'd5, 16'd32,   16'd4, 16'd4, 16'd8,    1'b0, 1'b0, 16'h0200, 16'h1800, 1'b0);
        vecs[2] = mk(1'b0, 13'd0, 16'd0,    16'd0, 16'd8, 16'd0,    1'b0, 1'b0, 16'h0200, 16'h0000, 1'b0);
        vecs[3] = mk(1'b0, 13'd0, 16'd0,    16'd0, 16'd8, 16'd16,   1'b0, 1'b0, 16'h0400, 16'h0000, 1'b0);
        vecs[4] = mk(1'b1, 13'd2, 16'd10,   16'd0, 16'd8, 16'd0,    1'b1, 1'b1, 16'h0400, 16'h03FF, 1'b1);
        vecs[5] = mk(1'b1, 13'd7, 16'h01F7, 16'd2, 16'd1, 16'd0,    1'b1, 1'b0, 16'h0400, 16'hFF80, 1'b1);
        vecs[6] = mk(1'b0, 13'd0, 16'd0,    16'd0, 16'd1, 16'h00FB, 1'b0, 1'b0, 16'hFF00, 16'h0000, 1'b1);
        vecs[7] = mk(1'b1, 13'd7, 16'd1,    16'd1, 16'd1, 16'd2,    1'b0, 1'b0, 16'h0100, 16'h0200, 1'b1);
        vecs[8] = mk(1'b1, 13'd3, 16'h0100, 16'd1, 16'd1, 16'd0,    1'b1, 1'b0, 16'h0100, 16'h00FF, 1'b1);
        vecs[9] = mk(1'b0, 13'd0, 16'd0,    16'd0, 16'd1, 16'h0100, 1'b0, 1'b0, 16'h00FF, 16'h0000, 1'b1);
        vrst    = mk(1'b1, 13'd3, 16'd1,    16'd1, 16'd1, 16'd0,    1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        vpost   = mk(1'b1, 13'd3, 16'd1,    16'd1, 16'd2, 16'd5,    1'b0, 1'b0, 16'h0000, 16'h01FF, 1'b0);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst.vtime", {16'd0, vtime}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.tag_valid", {31'd0, tag_valid}, 32'd0);
        chk("rst.err_ovf", {31'd0, err_ovf}, 32'd0);
        chk("rst.finish_tag", {16'd0, finish_tag}, 32'd0);
        chk("rst.tag_flow", {19'd0, tag_flow}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_event(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of DIV_F: no tag, no F_last write.
        @(negedge clk);
        drive(vrst);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) evt_valid = 1'b0;
        end
        chk("midrst.busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.vtime", {16'd0, vtime}, 32'd0);
        chk("midrst.err_ovf", {31'd0, err_ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (tag_valid) stray++;
        end
        chk("midrst.no_tag", stray, 32'd0);

        // F_last survives reset; sum_w_prev restarted at 0.
        run_event(vpost, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/virtual_time_tag.md
VIRTUAL_TIME_TAG -- requirements
Module: virtual_time_tag

Interface
REQ-001 SHALL have parameter N, default 16, datapath width; flow index width is N-3.
REQ-002 SHALL have parameter F_SHIFT, default 8, fixed-point fraction bits of virtual time and tags.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port evt_valid  input  1  one-cycle strobe; the event fields below are valid.
REQ-006 SHALL have port evt_arrival  input  1  1 = arrival, 0 = departure.
REQ-007 SHALL have port flow_id  input  N-3  flow index of the event.
REQ-008 SHALL have port pkt_len  input  N  packet length; used on arrivals only.
REQ-009 SHALL have port sum_w  input  N  sum of active weights after this event, from the sum-weight stage.
REQ-010 SHALL have port flow_w  input  N  weight of flow_id.
REQ-011 SHALL have port delta_t  input  N  cycles elapsed since the previous event.
REQ-012 SHALL have port flow_idle  input  1  flow had no backlog before this arrival.
REQ-013 SHALL have port busy  output  1  computation in progress; events are not accepted.
REQ-014 SHALL have port vtime  output  N  current virtual time.
REQ-015 SHALL have port tag_valid  output  1  one-cycle strobe for a finish tag.
REQ-016 SHALL have port finish_tag  output  N  finish tag of the tagged packet.
REQ-017 SHALL have port tag_flow  output  N-3  flow index of the tag.
REQ-018 SHALL have port err_ovf  output  1  sticky flag: an event was dropped.

Function
REQ-019 SHALL accept an event when evt_valid=1 and busy=0 (cycle 0) and capture all event inputs.
REQ-020 SHALL use FSM states IDLE, DIV_V (cycles 1-16), UPD_V (17), RD_F (18), DIV_F (19-34), TAG (35).
REQ-021 DIV_V SHALL compute inc = (delta_t << F_SHIFT) / sum_w_prev; sum_w_prev holds the sum_w of the previous accepted event (0 after reset).
REQ-022 UPD_V SHALL set vtime = vtime + inc mod 2^N and sum_w_prev = captured sum_w; vtime SHALL be visible at cycle 18.
REQ-023 A departure SHALL return to IDLE after UPD_V, with busy=0 at cycle 18.
REQ-024 On an arrival, RD_F SHALL read F_last[flow_id] and set S = vtime if flow_idle=1; otherwise S = later of (vtime, F_last) under serial-number comparison (the signed N-bit difference decides).
REQ-025 DIV_F SHALL compute q = (pkt_len << F_SHIFT) / flow_w; TAG SHALL compute F = S + q mod 2^N and write F to F_last[flow_id].
REQ-026 At cycle 36, tag_valid SHALL be 1 for exactly one cycle with finish_tag=F and tag_flow=captured flow_id, and busy SHALL be 0.
REQ-027 A divisor of 0 SHALL yield quotient 0 for DIV_V (vtime holds) and 2^N-1 for DIV_F.
REQ-028 A quotient exceeding 2^N-1 SHALL saturate to 2^N-1.
REQ-029 Any evt_valid=1 while busy=1 SHALL drop the event and set err_ovf=1; err_ovf SHALL clear only on reset.
REQ-030 An event accepted in the same cycle that busy falls SHALL be processed normally; evt_valid in IDLE with busy=0 is never dropped.

Reset
REQ-031 rst SHALL asynchronously force state=IDLE, busy=0, vtime=0, sum_w_prev=0, tag_valid=0, finish_tag=0, tag_flow=0, err_ovf=0.
REQ-032 Reset mid-operation SHALL abort the computation without writing F_last and without asserting tag_valid.
REQ-033 F_last contents SHALL NOT be cleared by reset; flows restart via flow_idle=1.

Structure
REQ-034 A shared package wfq_pkg SHALL hold N, F_SHIFT, the flow index width, and the FSM state encoding.
REQ-035 SHALL instantiate one sub-module, seq_div: a restoring divider with start/done, N iterations, divide-by-zero and overflow saturation; it is shared by DIV_V and DIV_F.
REQ-036 F_last SHALL be a single-port block RAM of 2^(N-3) x N with 1-cycle read latency.

Verification
REQ-037 Reset -> vtime=0, busy=0, tag_valid=0, err_ovf=0.
REQ-038 Arrival flow 5, w=4, L=64, flow_idle=1, delta_t=10, sum_w=4, sum_w_prev=0 -> vtime stays 0; tag_valid at cycle 36 with finish_tag=4096, tag_flow=5.
REQ-039 Next arrival flow 5, flow_idle=0, L=32, w=4, delta_t=8, sum_w=4 -> vtime=512; finish_tag=6144.
REQ-040 Departure with delta_t=16, sum_w_prev=8 -> vtime increases by 512; busy falls at cycle 18; no tag_valid.
REQ-041 Arrival with flow_w=0 -> finish_tag = S + 0xFFFF mod 2^16; second evt_valid at cycle 5 -> err_ovf=1, only one tag produced.
REQ-042 vtime=0xFF00 plus inc=0x200 -> vtime=0x0100; non-idle arrival with F_last=0xFF80 -> S=0x0100.
